// File: rtl/mule_scheduler.sv
// mule_scheduler: shares one multi-cycle MULE multiply unit between two issue
// requesters (pipe0/pipe1). Round-robin grant, operand capture, single-outstanding
// valid/accept/done sequencing, response routing to the owner, flush, timeout
// abort, and issue/latency statistics.
//
// Ports:
//   clk, rst                 clock; synchronous active-low reset
//   flush_i                  kill any in-flight request (no response)
//   req_valid_i/req_ready_o  per-requester request handshake (ready is combinational)
//   req{0,1}_{ra,rb,rd,op}_i requester operands, destination and opcode
//   unit_valid_o/accept_i    operation handshake to MULE, registered fields on unit_*_o
//   unit_done_i/result_i     MULE completion pulse and result
//   unit_abort_o             1-cycle abort pulse on timeout
//   resp_valid_o/ready_i     one-hot response handshake to the owner
//   resp_rd_o/result_o/error_o  response payload
//   busy_o                   scheduler not idle
//   issue_count_o            accepted unit operations (wrapping)
//   last_latency_o           accept-to-done cycles of last completed op (saturating)
module mule_scheduler #(
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned RD_W    = 5,
    parameter int unsigned OP_W    = 2,
    parameter int unsigned TIMEOUT = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush_i,
    input  logic [1:0]        req_valid_i,
    output logic [1:0]        req_ready_o,
    input  logic [DATA_W-1:0] req0_ra_i,
    input  logic [DATA_W-1:0] req0_rb_i,
    input  logic [RD_W-1:0]   req0_rd_i,
    input  logic [OP_W-1:0]   req0_op_i,
    input  logic [DATA_W-1:0] req1_ra_i,
    input  logic [DATA_W-1:0] req1_rb_i,
    input  logic [RD_W-1:0]   req1_rd_i,
    input  logic [OP_W-1:0]   req1_op_i,
    output logic              unit_valid_o,
    input  logic              unit_accept_i,
    output logic [DATA_W-1:0] unit_ra_o,
    output logic [DATA_W-1:0] unit_rb_o,
    output logic [OP_W-1:0]   unit_op_o,
    input  logic              unit_done_i,
    input  logic [DATA_W-1:0] unit_result_i,
    output logic              unit_abort_o,
    output logic [1:0]        resp_valid_o,
    input  logic [1:0]        resp_ready_i,
    output logic [RD_W-1:0]   resp_rd_o,
    output logic [DATA_W-1:0] resp_result_o,
    output logic              resp_error_o,
    output logic              busy_o,
    output logic [31:0]       issue_count_o,
    output logic [15:0]       last_latency_o
);

    localparam int unsigned TMR_W = $clog2(TIMEOUT + 1);
    localparam int unsigned CNT_W = 32;
    localparam int unsigned LAT_W = 16;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        ISSUE = 3'd1,
        WAIT  = 3'd2,
        RESP  = 3'd3,
        DRAIN = 3'd4
    } state_t;

    state_t              state_q, state_d;
    logic                last_grant_q;
    logic                owner_q;
    logic [DATA_W-1:0]   ra_q, rb_q, result_q;
    logic [RD_W-1:0]     rd_q;
    logic [OP_W-1:0]     op_q;
    logic                error_q;
    logic [TMR_W-1:0]    timer_q;
    logic [CNT_W-1:0]    issue_count_q;
    logic [LAT_W-1:0]    last_latency_q;
    logic                unit_valid_q;
    logic [1:0]          resp_valid_q;
    logic                busy_q;

    logic                grant_valid_c;
    logic                grant_idx_c;
    logic                accept_c;
    logic                abort_c;
    logic                latch_done_c;
    logic                latch_timeout_c;
    logic                update_last_c;
    logic                timer_limit_c;
    logic [31:0]         latency_full_c;
    logic [LAT_W-1:0]    latency_c;

    // Timer ">=" rather than "==" so a flush landing exactly on the limit still aborts from DRAIN.
    assign timer_limit_c  = (timer_q >= TMR_W'(TIMEOUT - 1));
    assign latency_full_c = 32'(timer_q) + 32'd1;
    assign latency_c      = (latency_full_c > 32'h0000_FFFF) ? 16'hFFFF : latency_full_c[LAT_W-1:0];

    // State register.
    always_ff @(posedge clk) begin
        if (!rst) state_q <= IDLE;
        else      state_q <= state_d;
    end

    // Next state, grant and control strobes; flush takes priority everywhere.
    always_comb begin
        state_d         = state_q;
        grant_valid_c   = 1'b0;
        grant_idx_c     = 1'b0;
        accept_c        = 1'b0;
        abort_c         = 1'b0;
        latch_done_c    = 1'b0;
        latch_timeout_c = 1'b0;
        update_last_c   = 1'b0;
        case (state_q)
            IDLE: begin
                if (!flush_i) begin
                    case (req_valid_i)
                        2'b01:   begin grant_valid_c = 1'b1; grant_idx_c = 1'b0;          end
                        2'b10:   begin grant_valid_c = 1'b1; grant_idx_c = 1'b1;          end
                        2'b11:   begin grant_valid_c = 1'b1; grant_idx_c = ~last_grant_q; end
                        default: grant_valid_c = 1'b0;
                    endcase
                    if (grant_valid_c) state_d = ISSUE;
                end
            end
            ISSUE: begin
                if (unit_accept_i) begin
                    accept_c = 1'b1;
                    state_d  = flush_i ? DRAIN : WAIT;
                end else if (flush_i) begin
                    state_d = IDLE;
                end
                update_last_c = flush_i;
            end
            WAIT: begin
                if (flush_i) begin
                    state_d       = DRAIN;
                    update_last_c = 1'b1;
                end else if (unit_done_i) begin
                    latch_done_c = 1'b1;
                    state_d      = RESP;
                end else if (timer_limit_c) begin
                    abort_c         = 1'b1;
                    latch_timeout_c = 1'b1;
                    state_d         = RESP;
                end
            end
            RESP: begin
                if (flush_i || resp_ready_i[owner_q]) begin
                    state_d       = IDLE;
                    update_last_c = 1'b1;
                end
            end
            DRAIN: begin
                if (unit_done_i) begin
                    state_d = IDLE;
                end else if (timer_limit_c) begin
                    abort_c = 1'b1;
                    state_d = IDLE;
                end
                update_last_c = flush_i;
            end
            default: state_d = IDLE;
        endcase
    end

    // Datapath, statistics and registered outputs.
    always_ff @(posedge clk) begin
        if (!rst) begin
            last_grant_q   <= 1'b1;
            owner_q        <= 1'b0;
            ra_q           <= '0;
            rb_q           <= '0;
            rd_q           <= '0;
            op_q           <= '0;
            result_q       <= '0;
            error_q        <= 1'b0;
            timer_q        <= '0;
            issue_count_q  <= '0;
            last_latency_q <= '0;
            unit_valid_q   <= 1'b0;
            resp_valid_q   <= 2'b00;
            busy_q         <= 1'b0;
        end else begin
            unit_valid_q <= (state_d == ISSUE);
            busy_q       <= (state_d != IDLE);
            resp_valid_q <= (state_d == RESP) ? (owner_q ? 2'b10 : 2'b01) : 2'b00;

            if (grant_valid_c) begin
                owner_q <= grant_idx_c;
                ra_q    <= grant_idx_c ? req1_ra_i : req0_ra_i;
                rb_q    <= grant_idx_c ? req1_rb_i : req0_rb_i;
                rd_q    <= grant_idx_c ? req1_rd_i : req0_rd_i;
                op_q    <= grant_idx_c ? req1_op_i : req0_op_i;
            end

            if (update_last_c) last_grant_q <= owner_q;

            if (accept_c) begin
                issue_count_q <= issue_count_q + CNT_W'(1);
                timer_q       <= '0;
            end else if (state_q == WAIT || state_q == DRAIN) begin
                timer_q <= timer_q + TMR_W'(1);
            end

            if (latch_done_c) begin
                result_q       <= unit_result_i;
                error_q        <= 1'b0;
                last_latency_q <= latency_c;
            end else if (latch_timeout_c) begin
                result_q <= '0;
                error_q  <= 1'b1;
            end
        end
    end

    assign req_ready_o    = grant_valid_c ? (grant_idx_c ? 2'b10 : 2'b01) : 2'b00;
    assign unit_abort_o   = abort_c;
    assign unit_valid_o   = unit_valid_q;
    assign unit_ra_o      = ra_q;
    assign unit_rb_o      = rb_q;
    assign unit_op_o      = op_q;
    assign resp_valid_o   = resp_valid_q;
    assign resp_rd_o      = rd_q;
    assign resp_result_o  = result_q;
    assign resp_error_o   = error_q;
    assign busy_o         = busy_q;
    assign issue_count_o  = issue_count_q;
    assign last_latency_o = last_latency_q;

endmodule

// File: tb/tb_mule_scheduler.sv
// Directed bench for mule_scheduler (TIMEOUT=8): single op, round-robin ties,
// response stall, flush in IDLE/WAIT/ISSUE+accept, timeout abort, mid-op reset.
module tb_mule_scheduler;

    localparam int unsigned DATA_W = 32;
    localparam int unsigned RD_W   = 5;
    localparam int unsigned OP_W   = 2;

    logic              clk = 1'b0;
    logic              rst;
    logic              flush;
    logic [1:0]        req_valid;
    logic [1:0]        req_ready;
    logic [DATA_W-1:0] req0_ra, req0_rb, req1_ra, req1_rb;
    logic [RD_W-1:0]   req0_rd, req1_rd;
    logic [OP_W-1:0]   req0_op, req1_op;
    logic              unit_valid;
    logic              unit_accept;
    logic [DATA_W-1:0] unit_ra, unit_rb;
    logic [OP_W-1:0]   unit_op;
    logic              unit_done;
    logic [DATA_W-1:0] unit_result;
    logic              unit_abort;
    logic [1:0]        resp_valid;
    logic [1:0]        resp_ready;
    logic [RD_W-1:0]   resp_rd;
    logic [DATA_W-1:0] resp_result;
    logic              resp_error;
    logic              busy;
    logic [31:0]       issue_count;
    logic [15:0]       last_latency;

    int n_tests = 0;
    int n_fail  = 0;
    logic [31:0] exp_count = 32'd0;

    mule_scheduler #(.DATA_W(DATA_W), .RD_W(RD_W), .OP_W(OP_W), .TIMEOUT(8)) dut (
        .clk(clk), .rst(rst), .flush_i(flush),
        .req_valid_i(req_valid), .req_ready_o(req_ready),
        .req0_ra_i(req0_ra), .req0_rb_i(req0_rb), .req0_rd_i(req0_rd), .req0_op_i(req0_op),
        .req1_ra_i(req1_ra), .req1_rb_i(req1_rb), .req1_rd_i(req1_rd), .req1_op_i(req1_op),
        .unit_valid_o(unit_valid), .unit_accept_i(unit_accept),
        .unit_ra_o(unit_ra), .unit_rb_o(unit_rb), .unit_op_o(unit_op),
        .unit_done_i(unit_done), .unit_result_i(unit_result), .unit_abort_o(unit_abort),
        .resp_valid_o(resp_valid), .resp_ready_i(resp_ready),
        .resp_rd_o(resp_rd), .resp_result_o(resp_result), .resp_error_o(resp_error),
        .busy_o(busy), .issue_count_o(issue_count), .last_latency_o(last_latency)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog obs=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Full transaction for requester g; requester 0 = {3,4,rd1,op0}, requester 1 = {5,6,rd2,op3}.
    // MULE done one cycle after accept (latency 1); response stalled 'stall' cycles with
    // only the non-owner's ready raised.
    task automatic run_op(input logic g, input logic [1:0] valid, input logic [31:0] res, input int stall);
        logic [1:0] oh;
        oh = g ? 2'b10 : 2'b01;
        req_valid = valid;
        #1;
        chk("op_grant", 64'(req_ready), 64'(oh));
        tick();
        chk("op_unit_valid", 64'(unit_valid), 64'd1);
        chk("op_unit_ra", 64'(unit_ra), g ? 64'd5 : 64'd3);
        chk("op_unit_rb", 64'(unit_rb), g ? 64'd6 : 64'd4);
        chk("op_unit_op", 64'(unit_op), g ? 64'd3 : 64'd0);
        unit_accept = 1'b1;
        tick();
        unit_accept = 1'b0;
        exp_count = exp_count + 32'd1;
        chk("op_issue_count", 64'(issue_count), 64'(exp_count));
        unit_done   = 1'b1;
        unit_result = res;
        tick();
        unit_done   = 1'b0;
        resp_ready  = ~oh;
        for (int i = 0; i <= stall; i++) begin
            #1;
            chk("op_resp_valid", 64'(resp_valid), 64'(oh));
            chk("op_resp_result", 64'(resp_result), 64'(res));
            chk("op_resp_rd", 64'(resp_rd), g ? 64'd2 : 64'd1);
            chk("op_resp_error", 64'(resp_error), 64'd0);
            chk("op_no_grant_in_resp", 64'(req_ready), 64'd0);
            if (i < stall) tick();
        end
        chk("op_latency", 64'(last_latency), 64'd1);
        resp_ready = oh;
        tick();
        resp_ready = 2'b00;
        chk("op_resp_cleared", 64'(resp_valid), 64'd0);
    endtask

    initial begin
        rst = 1'b0; flush = 1'b0; req_valid = 2'b00; resp_ready = 2'b00;
        unit_accept = 1'b0; unit_done = 1'b0; unit_result = '0;
        req0_ra = 32'd7; req0_rb = 32'd9; req0_rd = 5'd5; req0_op = 2'd0;
        req1_ra = 32'd5; req1_rb = 32'd6; req1_rd = 5'd2; req1_op = 2'd3;
        tick(); tick();
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_unit_valid", 64'(unit_valid), 64'd0);
        chk("rst_resp_valid", 64'(resp_valid), 64'd0);
        chk("rst_issue_count", 64'(issue_count), 64'd0);
        chk("rst_latency", 64'(last_latency), 64'd0);
        chk("rst_abort", 64'(unit_abort), 64'd0);
        rst = 1'b1;
        tick();

        // Basic op: 7*9, done 3 cycles after accept.
        req_valid = 2'b01;
        #1;
        chk("t1_grant", 64'(req_ready), 64'd1);
        tick();
        req_valid = 2'b00;
        chk("t1_unit_valid", 64'(unit_valid), 64'd1);
        chk("t1_unit_ra", 64'(unit_ra), 64'd7);
        chk("t1_unit_rb", 64'(unit_rb), 64'd9);
        chk("t1_busy", 64'(busy), 64'd1);
        unit_accept = 1'b1;
        tick();
        unit_accept = 1'b0;
        chk("t1_issue_count", 64'(issue_count), 64'd1);
        chk("t1_unit_valid_drop", 64'(unit_valid), 64'd0);
        tick();
        tick();
        unit_done = 1'b1; unit_result = 32'd63;
        tick();
        unit_done = 1'b0;
        chk("t1_resp_valid", 64'(resp_valid), 64'd1);
        chk("t1_resp_result", 64'(resp_result), 64'd63);
        chk("t1_resp_rd", 64'(resp_rd), 64'd5);
        chk("t1_latency", 64'(last_latency), 64'd3);
        resp_ready = 2'b01;
        tick();
        resp_ready = 2'b00;
        chk("t1_idle", 64'(busy), 64'd0);

        // Reset restores tie priority to requester 0.
        rst = 1'b0;
        tick();
        rst = 1'b1;
        exp_count = 32'd0;
        chk("rst2_issue_count", 64'(issue_count), 64'd0);
        req0_ra = 32'd3; req0_rb = 32'd4; req0_rd = 5'd1; req0_op = 2'd0;

        // Continuous ties alternate 0,1,0.
        run_op(1'b0, 2'b11, 32'd12, 0);
        run_op(1'b1, 2'b11, 32'd30, 0);
        run_op(1'b0, 2'b11, 32'd12, 0);
        chk("t2_issue_count", 64'(issue_count), 64'd3);

        // Stalled response for 5 cycles; next tie goes to requester 1.
        run_op(1'b1, 2'b11, 32'hDEAD_BEEF, 5);
        req_valid = 2'b00;

        // Flush during WAIT; done arrives two cycles later while draining.
        req_valid = 2'b01;
        #1;
        chk("t4_grant", 64'(req_ready), 64'd1);
        tick();
        req_valid = 2'b00;
        unit_accept = 1'b1;
        tick();
        unit_accept = 1'b0;
        exp_count = exp_count + 32'd1;
        flush = 1'b1;
        tick();
        flush = 1'b0;
        chk("t4_drain_busy", 64'(busy), 64'd1);
        chk("t4_no_resp", 64'(resp_valid), 64'd0);
        tick();
        unit_done = 1'b1; unit_result = 32'd99;
        #1;
        chk("t4_no_abort", 64'(unit_abort), 64'd0);
        tick();
        unit_done = 1'b0;
        chk("t4_idle", 64'(busy), 64'd0);
        chk("t4_no_resp2", 64'(resp_valid), 64'd0);
        chk("t4_latency_kept", 64'(last_latency), 64'd1);
        chk("t4_issue_count", 64'(issue_count), 64'(exp_count));
        run_op(1'b1, 2'b10, 32'd77, 0);
        req_valid = 2'b00;

        // Timeout: abort on the 8th WAIT cycle, error response with zero result.
        req_valid = 2'b01;
        tick();
        req_valid = 2'b00;
        unit_accept = 1'b1;
        tick();
        unit_accept = 1'b0;
        exp_count = exp_count + 32'd1;
        for (int w = 1; w <= 8; w++) begin
            chk($sformatf("t5_abort_w%0d", w), 64'(unit_abort), (w == 8) ? 64'd1 : 64'd0);
            tick();
        end
        chk("t5_resp_valid", 64'(resp_valid), 64'd1);
        chk("t5_resp_error", 64'(resp_error), 64'd1);
        chk("t5_resp_result", 64'(resp_result), 64'd0);
        chk("t5_abort_single", 64'(unit_abort), 64'd0);
        chk("t5_latency_kept", 64'(last_latency), 64'd1);
        resp_ready = 2'b01;
        tick();
        resp_ready = 2'b00;
        chk("t5_idle", 64'(busy), 64'd0);

        // Flush in IDLE blocks the grant.
        req_valid = 2'b01; flush = 1'b1;
        #1;
        chk("t6_idle_flush_ready", 64'(req_ready), 64'd0);
        tick();
        flush = 1'b0;
        chk("t6_idle_flush_busy", 64'(busy), 64'd0);

        // Flush in the same cycle as accept: counted, drained, no response.
        #1;
        chk("t7_grant", 64'(req_ready), 64'd1);
        tick();
        req_valid = 2'b00;
        unit_accept = 1'b1; flush = 1'b1;
        tick();
        unit_accept = 1'b0; flush = 1'b0;
        exp_count = exp_count + 32'd1;
        chk("t7_issue_count", 64'(issue_count), 64'(exp_count));
        chk("t7_drain_busy", 64'(busy), 64'd1);
        chk("t7_unit_valid", 64'(unit_valid), 64'd0);
        unit_done = 1'b1;
        tick();
        unit_done = 1'b0;
        chk("t7_idle", 64'(busy), 64'd0);
        chk("t7_no_resp", 64'(resp_valid), 64'd0);

        // Reset in the middle of WAIT.
        req_valid = 2'b10;
        tick();
        req_valid = 2'b00;
        unit_accept = 1'b1;
        tick();
        unit_accept = 1'b0;
        rst = 1'b0;
        tick();
        chk("t8_busy", 64'(busy), 64'd0);
        chk("t8_abort", 64'(unit_abort), 64'd0);
        chk("t8_issue_count", 64'(issue_count), 64'd0);
        rst = 1'b1;
        tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
